// File: rtl/lint_mem_responder_pkg.sv
// Shared types and helpers for the LINT memory responder.
package lint_mem_responder_pkg;

  // Wait-state controller states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Response opcode values carried on r_opc
  localparam logic LINT_OPC_OK  = 1'b0;
  localparam logic LINT_OPC_ERR = 1'b1;

  // Number of address bits that select a byte inside one data word
  function automatic int unsigned byte_off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/lint_wait_ctrl.sv
// Grant generator: holds off gnt until req has been asserted for WAIT_CYCLES
// consecutive cycles. A dropped request aborts the sequence.
module lint_wait_ctrl
  import lint_mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic gnt_o
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  state_e     state_reg;
  logic [3:0] cnt_reg;

  // State and wait counter; with zero wait states the FSM never leaves IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else if (WAIT_CNT != 4'd0) begin
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            state_reg <= WAIT;
            cnt_reg   <= 4'd1;
          end
        end
        WAIT: begin
          if (!req_i) begin
            // initiator withdrew the request: abandon without access
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == WAIT_CNT) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Grant is combinational so a zero-wait slave grants in the request cycle
  always_comb begin
    gnt_o = 1'b0;
    if (rst_i) begin
      gnt_o = 1'b0;
    end else if (WAIT_CNT == 4'd0) begin
      gnt_o = req_i;
    end else begin
      gnt_o = req_i && (state_reg == WAIT) && (cnt_reg == WAIT_CNT);
    end
  end

endmodule

// File: rtl/lint_mem_responder.sv
// LINT/TCDM slave: flop-based word memory with byte-enable writes,
// programmable grant wait states and a single-cycle registered response.
module lint_mem_responder
  import lint_mem_responder_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              NUM_WORDS     = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'h1A11_0000,
  parameter int unsigned              WAIT_CYCLES   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [ADDRESS_WIDTH-1:0]  add_i,
  input  logic                      wen_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [DATA_WIDTH-1:0]     r_rdata_o,
  output logic                      r_opc_o
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned BOFF_W    = byte_off_width(DATA_WIDTH);
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
  localparam logic [ADDRESS_WIDTH-1:0] SPAN = ADDRESS_WIDTH'(NUM_WORDS * NUM_BYTES);

  logic [DATA_WIDTH-1:0]    mem_reg [NUM_WORDS];
  logic                     r_valid_reg;
  logic                     r_opc_reg;
  logic [DATA_WIDTH-1:0]    r_rdata_reg;

  logic [ADDRESS_WIDTH-1:0] off;
  logic                     in_range;
  logic [IDX_W-1:0]         idx;
  logic                     gnt;
  logic                     access;
  logic                     wr_hit;
  logic [NUM_BYTES-1:0]     byte_we;

  lint_wait_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctrl (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_i),
    .gnt_o (gnt)
  );

  // Address decode relative to the window base; wraps, so addresses below
  // the base land far above the span and are flagged out of range
  assign off      = add_i - BASE_ADDR;
  assign in_range = (off < SPAN);
  assign idx      = off[BOFF_W +: IDX_W];

  assign access = req_i & gnt;
  assign wr_hit = access & ~wen_i & in_range;

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_we
    assign byte_we[gi] = wr_hit & be_i[gi];
  end

  // Memory array: cleared on reset, byte-masked writes at the grant edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem_reg[w] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byte_we[b]) begin
          mem_reg[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Response register: one-cycle valid pulse, data/opc hold between pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_reg <= 1'b0;
      r_opc_reg   <= LINT_OPC_OK;
      r_rdata_reg <= '0;
    end else begin
      r_valid_reg <= access;
      if (access) begin
        r_opc_reg   <= in_range ? LINT_OPC_OK : LINT_OPC_ERR;
        // read sees the pre-write contents; writes and errors return zero
        r_rdata_reg <= (wen_i && in_range) ? mem_reg[idx] : '0;
      end
    end
  end

  assign gnt_o     = gnt;
  assign r_valid_o = r_valid_reg;
  assign r_opc_o   = r_opc_reg;
  assign r_rdata_o = r_rdata_reg;

endmodule
